// File: rtl/alu_pipe.sv
// Pipelined RV32I integer ALU: LAT-cycle execute into an in-order output queue.
// Epoch-based flush kills in-flight and queued uops. The queue compacts so the oldest survivor stays at the head.
package alu_pipe_pkg;

  localparam int EPOCH_W = 2;
  localparam int ROB_W   = 5;
  localparam int PHYS_W  = 6;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLLI = 4'd11;
  localparam logic [3:0] OP_SRLI = 4'd12;
  localparam logic [3:0] OP_SRAI = 4'd13;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;
  localparam logic [1:0] SRC2_RS2  = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [1:0]  src1_select;
    logic [1:0]  src2_select;
    logic        uses_rd;
  } bundle_t;

  typedef struct packed {
    bundle_t             bundle;
    logic [ROB_W-1:0]    rob_idx;
    logic [PHYS_W-1:0]   prd_new;
    logic [EPOCH_W-1:0]  epoch;
  } rs_uop_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic                uses_rd;
    logic [ROB_W-1:0]    rob_idx;
    logic [PHYS_W-1:0]   prd_new;
    logic [EPOCH_W-1:0]  epoch;
    logic [31:0]         data;
  } wb_ent_t;

endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  rs_uop_t                       req_uop,
  input  logic [31:0]                   rs1_val,
  input  logic [31:0]                   rs2_val,
  input  logic                          flush_valid,
  input  logic [EPOCH_W-1:0]            flush_epoch,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [31:0]                   wb_pc,
  output logic                          wb_uses_rd,
  output logic [ROB_W-1:0]              wb_rob_idx,
  output logic [PHYS_W-1:0]             wb_prd_new,
  output logic [EPOCH_W-1:0]            wb_epoch,
  output logic [31:0]                   wb_data,
  output logic [$clog2(QDEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(QDEPTH+1);
  localparam int NSTG  = (LAT > 1) ? LAT - 1 : 1;

  logic [31:0]             op_a;
  logic [31:0]             op_b;
  logic [31:0]             result;
  wb_ent_t                 acc_ent;
  logic                    acc_fire;
  logic                    deq_fire;

  logic [NSTG-1:0]         stg_vld;
  wb_ent_t [NSTG-1:0]      stg_ent;
  logic                    qin_vld;
  wb_ent_t                 qin_ent;

  wb_ent_t [QDEPTH-1:0]    q;
  wb_ent_t [QDEPTH-1:0]    q_nxt;
  logic [OCC_W-1:0]        q_cnt;
  logic [OCC_W-1:0]        cnt_nxt;
  int                      occ_sum;

  function automatic logic kill(input logic [EPOCH_W-1:0] ep);
    return flush_valid && (ep != flush_epoch);
  endfunction

  always_comb begin
    op_a = '0;
    case (req_uop.bundle.src1_select)
      SRC1_RS1: op_a = rs1_val;
      SRC1_PC:  op_a = req_uop.bundle.pc;
      default:  op_a = '0;
    endcase
    op_b = '0;
    case (req_uop.bundle.src2_select)
      SRC2_RS2: op_b = rs2_val;
      SRC2_IMM: op_b = req_uop.bundle.imm;
      default:  op_b = '0;
    endcase
  end

  // The whole op resolves at accept; the stages only model latency.
  always_comb begin
    result = '0;
    case (req_uop.bundle.op)
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_SLT:  result = {31'b0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: result = {31'b0, op_a < op_b};
      OP_LUI:  result = op_b;
      OP_SLL:  result = op_a << op_b[4:0];
      OP_SRL:  result = op_a >> op_b[4:0];
      OP_SRA:  result = $unsigned($signed(op_a) >>> op_b[4:0]);
      OP_SLLI: result = op_a << req_uop.bundle.imm[4:0];
      OP_SRLI: result = op_a >> req_uop.bundle.imm[4:0];
      OP_SRAI: result = $unsigned($signed(op_a) >>> req_uop.bundle.imm[4:0]);
      default: result = '0;
    endcase
  end

  always_comb begin
    acc_ent         = '0;
    acc_ent.pc      = req_uop.bundle.pc;
    acc_ent.uses_rd = req_uop.bundle.uses_rd;
    acc_ent.rob_idx = req_uop.rob_idx;
    acc_ent.prd_new = req_uop.prd_new;
    acc_ent.epoch   = req_uop.epoch;
    acc_ent.data    = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      stg_ent <= '0;
    end else if (LAT > 1) begin
      stg_vld[0] <= acc_fire && !kill(acc_ent.epoch);
      stg_ent[0] <= acc_ent;
      for (int k = 1; k < NSTG; k++) begin
        stg_vld[k] <= stg_vld[k-1] && !kill(stg_ent[k-1].epoch);
        stg_ent[k] <= stg_ent[k-1];
      end
    end
  end

  assign qin_vld = (LAT == 1) ? acc_fire : stg_vld[NSTG-1];
  assign qin_ent = (LAT == 1) ? acc_ent  : stg_ent[NSTG-1];

  // Rebuild the queue each cycle: drop the dequeued head, squeeze out killed entries, append.
  always_comb begin
    int wp;
    int idx;
    q_nxt = '0;
    wp    = 0;
    idx   = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = i + (deq_fire ? 1 : 0);
      if (idx < int'(q_cnt) && idx < QDEPTH) begin
        if (!kill(q[idx].epoch)) begin
          q_nxt[wp] = q[idx];
          wp = wp + 1;
        end
      end
    end
    if (qin_vld && !kill(qin_ent.epoch) && wp < QDEPTH) begin
      q_nxt[wp] = qin_ent;
      wp = wp + 1;
    end
    cnt_nxt = OCC_W'(wp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      q_cnt <= '0;
    end else begin
      q     <= q_nxt;
      q_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    occ_sum = int'(q_cnt);
    for (int k = 0; k < NSTG; k++) begin
      occ_sum = occ_sum + (stg_vld[k] ? 1 : 0);
    end
  end

  // Reserving a slot at accept means the queue can never overflow.
  assign req_ready  = (occ_sum - (deq_fire ? 1 : 0)) < QDEPTH;
  assign acc_fire   = req_valid && req_ready;
  assign wb_valid   = (q_cnt != '0);
  assign deq_fire   = wb_valid && wb_ready;
  assign occupancy  = OCC_W'(occ_sum);

  assign wb_pc      = q[0].pc;
  assign wb_uses_rd = q[0].uses_rd;
  assign wb_rob_idx = q[0].rob_idx;
  assign wb_prd_new = q[0].prd_new;
  assign wb_epoch   = q[0].epoch;
  assign wb_data    = q[0].data;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: instance A (LAT=1, QDEPTH=3) and B (LAT=3, QDEPTH=4) share stimulus.
// Each scenario targets one instance through sel and checks against a queue-level model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic flush_valid = 1'b0;
  logic [EPOCH_W-1:0] flush_epoch = '0;
  rs_uop_t req_uop = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic wb_rdy = 1'b0;
  logic sel = 1'b0;
  int total = 0;
  int bad = 0;

  logic a_req_ready, a_wb_valid, a_wb_uses_rd, b_req_ready, b_wb_valid, b_wb_uses_rd;
  logic [31:0] a_wb_pc, a_wb_data, b_wb_pc, b_wb_data;
  logic [ROB_W-1:0] a_wb_rob, b_wb_rob;
  logic [PHYS_W-1:0] a_wb_prd, b_wb_prd;
  logic [EPOCH_W-1:0] a_wb_epoch, b_wb_epoch;
  logic [1:0] a_occ;
  logic [2:0] b_occ;
  logic wb_ready_a, wb_ready_b;

  logic t_req_ready, t_wb_valid, t_wb_uses_rd;
  logic [31:0] t_wb_pc, t_wb_data;
  logic [ROB_W-1:0] t_wb_rob;
  logic [PHYS_W-1:0] t_wb_prd;
  logic [EPOCH_W-1:0] t_wb_epoch;
  logic [3:0] t_occ;

  always #5 clk = ~clk;

  assign wb_ready_a   = sel ? 1'b1 : wb_rdy;
  assign wb_ready_b   = sel ? wb_rdy : 1'b1;
  assign t_req_ready  = sel ? b_req_ready : a_req_ready;
  assign t_wb_valid   = sel ? b_wb_valid : a_wb_valid;
  assign t_wb_uses_rd = sel ? b_wb_uses_rd : a_wb_uses_rd;
  assign t_wb_pc      = sel ? b_wb_pc : a_wb_pc;
  assign t_wb_data    = sel ? b_wb_data : a_wb_data;
  assign t_wb_rob     = sel ? b_wb_rob : a_wb_rob;
  assign t_wb_prd     = sel ? b_wb_prd : a_wb_prd;
  assign t_wb_epoch   = sel ? b_wb_epoch : a_wb_epoch;
  assign t_occ        = sel ? {1'b0, b_occ} : {2'b0, a_occ};

  alu_pipe #(.LAT(1), .QDEPTH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_uop(req_uop), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush_valid(flush_valid), .flush_epoch(flush_epoch),
    .wb_valid(a_wb_valid), .wb_ready(wb_ready_a), .wb_pc(a_wb_pc), .wb_uses_rd(a_wb_uses_rd),
    .wb_rob_idx(a_wb_rob), .wb_prd_new(a_wb_prd), .wb_epoch(a_wb_epoch), .wb_data(a_wb_data),
    .occupancy(a_occ)
  );

  alu_pipe #(.LAT(3), .QDEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_uop(req_uop), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush_valid(flush_valid), .flush_epoch(flush_epoch),
    .wb_valid(b_wb_valid), .wb_ready(wb_ready_b), .wb_pc(b_wb_pc), .wb_uses_rd(b_wb_uses_rd),
    .wb_rob_idx(b_wb_rob), .wb_prd_new(b_wb_prd), .wb_epoch(b_wb_epoch), .wb_data(b_wb_data),
    .occupancy(b_occ)
  );

  function automatic rs_uop_t mk(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [4:0] rob, input logic [1:0] ep);
    rs_uop_t u;
    u = '0;
    u.bundle.op = op;
    u.bundle.src1_select = s1;
    u.bundle.src2_select = s2;
    u.bundle.pc = pc;
    u.bundle.imm = imm;
    u.bundle.uses_rd = rob[0];
    u.rob_idx = rob;
    u.prd_new = {1'b0, rob};
    u.epoch = ep;
    return u;
  endfunction

  // Reference result from the ISA rules using plain arithmetic.
  function automatic logic [31:0] ref_alu(input rs_uop_t u, input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] a, b;
    logic [63:0] w;
    int sh, shi;
    a = (u.bundle.src1_select == 2'd0) ? r1 : (u.bundle.src1_select == 2'd1) ? u.bundle.pc : 32'd0;
    b = (u.bundle.src2_select == 2'd0) ? r2 : (u.bundle.src2_select == 2'd1) ? u.bundle.imm : 32'd0;
    sh = int'(b % 32);
    shi = int'(u.bundle.imm % 32);
    case (u.bundle.op)
      OP_ADD:  return a + b;
      OP_SUB:  return a + ~b + 32'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_LUI:  return b;
      OP_SLL:  begin w = {32'd0, a} * (64'd1 << sh); return w[31:0]; end
      OP_SRL:  return a / (32'd1 << sh);
      OP_SRA:  begin w = {{32{a[31]}}, a}; w = w >> sh; return w[31:0]; end
      OP_SLLI: begin w = {32'd0, a} * (64'd1 << shi); return w[31:0]; end
      OP_SRLI: return a / (32'd1 << shi);
      OP_SRAI: begin w = {{32{a[31]}}, a}; w = w >> shi; return w[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    flush_valid = 1'b0;
    wb_rdy = 1'b0;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic drive(input rs_uop_t u, input logic [31:0] r1, input logic [31:0] r2);
    req_valid = 1'b1;
    req_uop = u;
    rs1_val = r1;
    rs2_val = r2;
  endtask

  task automatic test_reset;
    sel = 1'b0;
    rst_n = 1'b0;
    #2;
    total++; if (t_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h want=0", t_wb_valid); end
    total++; if (t_occ !== 4'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", t_occ); end
    total++; if (t_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0h want=1", t_req_ready); end
    total++; if (t_wb_data !== 32'd0 || t_wb_pc !== 32'd0) begin bad++; $display("FAIL rst_data_pc got=%h/%h want=0/0", t_wb_data, t_wb_pc); end
    total++; if (t_wb_rob !== '0 || t_wb_prd !== '0 || t_wb_epoch !== '0 || t_wb_uses_rd !== 1'b0) begin
      bad++; $display("FAIL rst_tags got=%h/%h/%h/%h want=0", t_wb_rob, t_wb_prd, t_wb_epoch, t_wb_uses_rd); end
    total++; if (b_wb_valid !== 1'b0 || b_occ !== 3'd0) begin bad++; $display("FAIL rst_b got=%0h/%0d want=0/0", b_wb_valid, b_occ); end
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    sel = 1'b0;
    do_reset();
    wb_rdy = 1'b1;
    drive(mk(OP_ADD, SRC1_RS1, SRC2_IMM, 32'h100, 32'hFFFF_FFF9, 5'd3, 2'd1), 32'd5, 32'd0);
    @(negedge clk);
    total++; if (t_req_ready !== 1'b1 || t_wb_valid !== 1'b0) begin bad++; $display("FAIL addi_t0 got rdy=%0h vld=%0h want 1/0", t_req_ready, t_wb_valid); end
    next_cyc();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (t_wb_valid !== 1'b1) begin bad++; $display("FAIL addi_vld got=%0h want=1", t_wb_valid); end
    total++; if (t_wb_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL addi_data got=%h want=fffffffe", t_wb_data); end
    total++; if (t_wb_rob !== 5'd3 || t_wb_pc !== 32'h100 || t_wb_uses_rd !== 1'b1) begin bad++; $display("FAIL addi_tags got=%h/%h/%h want=3/100/1", t_wb_rob, t_wb_pc, t_wb_uses_rd); end
    next_cyc();
    @(negedge clk);
    total++; if (t_wb_valid !== 1'b0 || t_occ !== 4'd0) begin bad++; $display("FAIL addi_drained got=%0h/%0d want=0/0", t_wb_valid, t_occ); end
  endtask

  task automatic test_back_to_back;
    sel = 1'b1;
    do_reset();
    wb_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(mk(OP_SRA, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd1, 2'd0), 32'h8000_0000, 32'd4);
      else if (c == 1) drive(mk(OP_SLTU, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd2, 2'd0), 32'd1, 32'd2);
      else req_valid = 1'b0;
      @(negedge clk);
      case (c)
        1: begin total++; if (t_occ !== 4'd1) begin bad++; $display("FAIL b2b_occ1 got=%0d want=1", t_occ); end end
        2: begin total++; if (t_occ !== 4'd2 || t_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_t2 got occ=%0d vld=%0h want 2/0", t_occ, t_wb_valid); end end
        3: begin total++; if (t_wb_valid !== 1'b1 || t_wb_data !== 32'hF800_0000) begin bad++; $display("FAIL b2b_sra got=%0h/%h want=1/f8000000", t_wb_valid, t_wb_data); end end
        4: begin total++; if (t_wb_valid !== 1'b1 || t_wb_data !== 32'd1) begin bad++; $display("FAIL b2b_sltu got=%0h/%h want=1/1", t_wb_valid, t_wb_data); end end
        5: begin total++; if (t_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0h want=0", t_wb_valid); end end
        default: begin total++; if (t_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_t0 got=%0h want=0", t_wb_valid); end end
      endcase
      next_cyc();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_d[$];
    rs_uop_t u;
    int acc;
    sel = 1'b0;
    do_reset();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      u = mk(OP_XOR, SRC1_RS1, SRC2_RS2, 32'h40 + 32'(i), 32'd0, 5'(i), 2'd0);
      drive(u, 32'h1000 + 32'(i), 32'h0F0F_0000);
      @(negedge clk);
      if (t_req_ready) begin exp_d.push_back(ref_alu(u, rs1_val, rs2_val)); acc++; end
      next_cyc();
    end
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (acc != 3) begin bad++; $display("FAIL bp_accepted got=%0d want=3", acc); end
    total++; if (t_occ !== 4'd3 || t_req_ready !== 1'b0) begin bad++; $display("FAIL bp_full got occ=%0d rdy=%0h want 3/0", t_occ, t_req_ready); end
    next_cyc();
    wb_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == 0) begin total++; if (t_req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%0h want=1", t_req_ready); end end
      total++; if (t_wb_valid !== 1'b1 || exp_d.size() == 0 || t_wb_data !== exp_d[0]) begin
        bad++; $display("FAIL bp_order%0d got=%0h/%h want=1/%h", j, t_wb_valid, t_wb_data, (exp_d.size() != 0) ? exp_d[0] : 32'hx); end
      if (exp_d.size() != 0) void'(exp_d.pop_front());
      next_cyc();
    end
    @(negedge clk);
    total++; if (t_wb_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h want=0", t_wb_valid); end
  endtask

  task automatic test_flush;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'(i), (i % 2 == 0) ? 2'd1 : 2'd2), 32'd200 + 32'(i), 32'd0);
      next_cyc();
    end
    req_valid = 1'b0;
    next_cyc();
    next_cyc();
    flush_valid = 1'b1;
    flush_epoch = 2'd2;
    drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd20, 2'd1), 32'd777, 32'd0);
    @(negedge clk);
    total++; if (t_occ !== 4'd4 || t_req_ready !== 1'b0 || t_wb_epoch !== 2'd1) begin
      bad++; $display("FAIL fl_full got occ=%0d rdy=%0h ep=%0d want 4/0/1", t_occ, t_req_ready, t_wb_epoch); end
    next_cyc();
    flush_valid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (t_occ !== 4'd2 || t_wb_epoch !== 2'd2 || t_wb_data !== 32'd201) begin
      bad++; $display("FAIL fl_compact got occ=%0d ep=%0d d=%0d want 2/2/201", t_occ, t_wb_epoch, t_wb_data); end
    next_cyc();
    flush_valid = 1'b1;
    drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd21, 2'd1), 32'd999, 32'd0);
    @(negedge clk);
    total++; if (t_req_ready !== 1'b1) begin bad++; $display("FAIL fl_drop_rdy got=%0h want=1", t_req_ready); end
    next_cyc();
    flush_valid = 1'b0;
    req_valid = 1'b0;
    repeat (4) next_cyc();
    @(negedge clk);
    total++; if (t_occ !== 4'd2) begin bad++; $display("FAIL fl_dropped got occ=%0d want=2", t_occ); end
    next_cyc();
    wb_rdy = 1'b1;
    @(negedge clk);
    total++; if (t_wb_data !== 32'd201) begin bad++; $display("FAIL fl_first got=%0d want=201", t_wb_data); end
    next_cyc();
    @(negedge clk);
    total++; if (t_wb_valid !== 1'b1 || t_wb_data !== 32'd203) begin bad++; $display("FAIL fl_second got=%0h/%0d want=1/203", t_wb_valid, t_wb_data); end
    next_cyc();
    @(negedge clk);
    total++; if (t_wb_valid !== 1'b0 || t_occ !== 4'd0) begin bad++; $display("FAIL fl_end got=%0h/%0d want=0/0", t_wb_valid, t_occ); end
  endtask

  task automatic test_flush_inflight;
    sel = 1'b1;
    do_reset();
    wb_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      flush_valid = (c == 1);
      flush_epoch = 2'd0;
      if (c == 0) drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd9, 2'd3), 32'd7, 32'd1);
      else if (c == 1) drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd10, 2'd0), 32'd40, 32'd2);
      else req_valid = 1'b0;
      @(negedge clk);
      if (c == 2 || c == 3) begin total++; if (t_occ !== 4'd1 || t_wb_valid !== 1'b0) begin bad++; $display("FAIL fi_occ%0d got=%0d/%0h want=1/0", c, t_occ, t_wb_valid); end end
      if (c == 4) begin total++; if (t_wb_valid !== 1'b1 || t_wb_data !== 32'd42 || t_wb_rob !== 5'd10) begin
        bad++; $display("FAIL fi_survivor got=%0h/%0d/%0d want=1/42/10", t_wb_valid, t_wb_data, t_wb_rob); end end
      if (c == 5) begin total++; if (t_wb_valid !== 1'b0 || t_occ !== 4'd0) begin bad++; $display("FAIL fi_end got=%0h/%0d want=0/0", t_wb_valid, t_occ); end end
      next_cyc();
    end
    flush_valid = 1'b0;
  endtask

  task automatic test_random(input logic s);
    logic [31:0] eq_d[$];
    logic [4:0] eq_r[$];
    rs_uop_t u;
    int acc, cyc;
    sel = s;
    do_reset();
    acc = 0;
    cyc = 0;
    while (!(acc >= 20 && eq_d.size() == 0) && cyc < 2000) begin
      wb_rdy = (acc >= 20) ? 1'b1 : ($urandom_range(0, 1) == 1);
      u = mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, 5'(acc), 2'd0);
      drive(u, $urandom, $urandom);
      req_valid = (acc < 20) && ($urandom_range(0, 3) != 0);
      @(negedge clk);
      total++; if (int'(t_occ) != eq_d.size()) begin bad++; $display("FAIL rnd%0d_occ cyc=%0d got=%0d want=%0d", s, cyc, t_occ, eq_d.size()); end
      if (t_wb_valid && wb_rdy) begin
        total++;
        if (eq_d.size() == 0) begin bad++; $display("FAIL rnd%0d_extra got=%h want=none", s, t_wb_data); end
        else begin
          if (t_wb_data !== eq_d[0] || t_wb_rob !== eq_r[0]) begin
            bad++; $display("FAIL rnd%0d_data got=%h/%0d want=%h/%0d", s, t_wb_data, t_wb_rob, eq_d[0], eq_r[0]); end
          void'(eq_d.pop_front());
          void'(eq_r.pop_front());
        end
      end
      if (req_valid && t_req_ready) begin
        eq_d.push_back(ref_alu(u, rs1_val, rs2_val));
        eq_r.push_back(5'(acc));
        acc++;
      end
      next_cyc();
      cyc++;
    end
    req_valid = 1'b0;
    total++; if (cyc >= 2000) begin bad++; $display("FAIL rnd%0d_timeout got acc=%0d left=%0d want 20/0", s, acc, eq_d.size()); end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    do_reset();
    drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd1, 2'd0), 32'd1, 32'd1);
    next_cyc();
    drive(mk(OP_ADD, SRC1_RS1, SRC2_RS2, 32'h0, 32'h0, 5'd2, 2'd0), 32'd2, 32'd2);
    next_cyc();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (t_occ !== 4'd2 || t_wb_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0d/%0h want=2/1", t_occ, t_wb_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (t_wb_valid !== 1'b0 || t_occ !== 4'd0 || t_req_ready !== 1'b1) begin
      bad++; $display("FAIL rm_async got vld=%0h occ=%0d rdy=%0h want 0/0/1", t_wb_valid, t_occ, t_req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (t_wb_valid !== 1'b0) begin bad++; $display("FAIL rm_post%0d got=%0h want=0", i, t_wb_valid); end
      next_cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_inflight();
    test_random(1'b0);
    test_random(1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
- REQ-001 Parameters SHALL be: LAT, default 1, execute latency in cycles from acceptance to earliest wb_valid (legal 1..4); QDEPTH, default 2, output queue entries (legal 1..8, power of two not required).
- REQ-002 Ports SHALL be, as name direction width meaning:
  clk in 1 clock, rising edge;
  rst_n in 1 reset, asynchronous, active-low;
  req_valid in 1 issue request;
  req_ready out 1 unit can accept this cycle;
  req_uop in rs_uop_t issued uop (bundle, rob_idx, prd_new, epoch);
  rs1_val in 32 source 1 operand;
  rs2_val in 32 source 2 operand;
  flush_valid in 1 pipeline flush;
  flush_epoch in EPOCH_W surviving epoch after flush;
  wb_valid out 1 queue head valid;
  wb_ready in 1 writeback consumer accepts head;
  wb_pc out 32 head pc;
  wb_uses_rd out 1 head writes rd;
  wb_rob_idx out ROB_W head ROB index;
  wb_prd_new out PHYS_W head destination phys reg;
  wb_epoch out EPOCH_W head epoch;
  wb_data out 32 head result;
  occupancy out $clog2(QDEPTH+1) queued plus in-flight entries.

Function
- REQ-003 Operand A SHALL be rs1_val, bundle.pc or zero per src1_select; operand B rs2_val or bundle.imm per src2_select; unlisted selects yield zero.
- REQ-004 Result SHALL implement RV32I ADD/ADDI/AUIPC, SUB, AND(I), OR(I), XOR(I), SLT(I), SLTU/SLTIU, LUI (=op B), SLLI/SRLI/SRAI using imm[4:0], SLL/SRL/SRA using op B[4:0]; unknown op yields 32'h0; all arithmetic mod 2^32.
- REQ-005 Accept fire SHALL be req_valid && req_ready; payload and result captured that cycle.
- REQ-006 Execute pipeline SHALL be LAT-1 register stages plus the queue write, never stalls; an entry accepted in cycle t SHALL be written into the queue at the end of cycle t+LAT-1 and be visible on wb_* no earlier than cycle t+LAT.
- REQ-007 Output queue SHALL be FIFO, in-order, QDEPTH entries; head drives wb_*; wb_valid SHALL equal queue non-empty.
- REQ-008 Dequeue fire SHALL be wb_valid && wb_ready; wb_* SHALL remain stable while wb_valid && !wb_ready.
- REQ-009 occupancy SHALL count valid in-flight stage entries plus queue entries; req_ready SHALL be (occupancy - deq_fire) < QDEPTH, guaranteeing the queue never overflows; wb_ready->req_ready combinational path is permitted.
- REQ-010 Simultaneous queue write and dequeue at full or empty SHALL both take effect; empty queue written and not dequeued shows wb_valid next cycle.
- REQ-011 Flush: in cycle with flush_valid, every in-flight and queued entry whose epoch != flush_epoch SHALL be invalidated at that edge; a request accepted in the same cycle with epoch != flush_epoch SHALL be dropped; surviving entries keep relative order and queue compacts so head is oldest survivor by the next cycle.
- REQ-012 wb_valid SHALL not present a killed entry in the cycle after flush; a head dequeued in the flush cycle itself counts as delivered.
- REQ-013 occupancy SHALL reflect kills on the cycle after flush.
- REQ-014 Pointer/count wrap SHALL be modulo QDEPTH with no lost or duplicated entry for non-power-of-two depths.

Reset
- REQ-015 rst_n low SHALL asynchronously clear all stage valids, queue pointers and count; wb_valid=0, occupancy=0, req_ready=1, wb_pc/wb_data/wb_rob_idx/wb_prd_new/wb_epoch=0, wb_uses_rd=0.
- REQ-016 Reset asserted mid-operation SHALL discard all entries; no wb_valid for pre-reset requests after release.

Verification
- REQ-017 LAT=1, QDEPTH=2, ADDI rs1=5 imm=-7 at t, wb_ready=1 -> wb_valid at t+1, wb_data=32'hFFFFFFFE, then dequeued.
- REQ-018 LAT=3, back-to-back SRA rs1=32'h80000000 rs2=4, then SLTU 1<2 -> wb_data 32'hF8000000 at t+3, 1 at t+4, in order.
- REQ-019 QDEPTH=3, wb_ready=0, issue 5 requests -> exactly 3 accepted, req_ready=0, occupancy=3; raise wb_ready -> 3 results in order, req_ready rises same cycle as first dequeue.
- REQ-020 QDEPTH=4, queue holds epochs 1,2,1,2, flush_valid with flush_epoch=2 -> next cycle two entries of epoch 2 remain in order, occupancy=2; same-cycle request epoch 1 dropped.
- REQ-021 QDEPTH=3, 20 random-stall ops through wrap -> scoreboard matches in-order results, no overflow.
- REQ-022 rst_n pulled low with 2 entries queued -> wb_valid=0, occupancy=0 immediately; nothing emitted after release.
